// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Holds the state enum, opcode/funct constants, and mux/ALU select codes.
package mips_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_RST      = 5'd0,
    ST_FETCH    = 5'd1,
    ST_DECODE   = 5'd2,
    ST_EXEC_R   = 5'd3,
    ST_WB_R     = 5'd4,
    ST_EXEC_I   = 5'd5,
    ST_WB_I     = 5'd6,
    ST_MEM_ADDR = 5'd7,
    ST_LW_READ  = 5'd8,
    ST_LW_WB    = 5'd9,
    ST_SW_WRITE = 5'd10,
    ST_BRANCH   = 5'd11,
    ST_JUMP     = 5'd12,
    ST_EXC      = 5'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b01;

  // Source-B code 3'b100 (register A) exists in the datapath but no state selects it.
  localparam logic [2:0] SRCB_B      = 3'b000;
  localparam logic [2:0] SRCB_4      = 3'b001;
  localparam logic [2:0] SRCB_IMM    = 3'b010;
  localparam logic [2:0] SRCB_IMM_SH = 3'b011;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  localparam logic EXC_OVF     = 1'b0;
  localparam logic EXC_ILLEGAL = 1'b1;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       epc_write;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  function automatic logic is_legal_r(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational control decode: state (plus funct/zero/opcode and the
// final-count flag of multi-cycle states) to every datapath enable and select.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        last,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        if (last) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCS_ALU;
        end
      end
      ST_DECODE: begin
        ctrl.ab_write      = 1'b1;
        ctrl.alu_src_a     = SRCA_PC;
        ctrl.alu_src_b     = SRCB_IMM_SH;
        ctrl.alu_op        = ALU_ADD;
        ctrl.alu_out_write = 1'b1;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a     = SRCA_A;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_out_write = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          default: ctrl.alu_op = 3'b000;
        endcase
      end
      ST_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        ctrl.alu_src_a     = SRCA_A;
        ctrl.alu_src_b     = SRCB_IMM;
        ctrl.alu_op        = ALU_ADD;
        ctrl.alu_out_write = 1'b1;
      end
      ST_WB_I: ctrl.reg_write = 1'b1;
      ST_LW_READ: begin
        ctrl.iord      = 1'b1;
        ctrl.mdr_write = last;
      end
      ST_LW_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_SW_WRITE: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCS_ALUOUT;
        ctrl.pc_write  = (opcode == OP_BEQ) ? zero : !zero;
      end
      ST_JUMP: begin
        ctrl.pc_source = PCS_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      ST_EXC: begin
        ctrl.epc_write = 1'b1;
        ctrl.pc_source = PCS_EXC;
        ctrl.pc_write  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_control_unit.sv
// Multicycle MIPS control FSM: state register, memory wait counter, trap
// cause register and next-state logic; output decode lives in mips_ctrl_decode.
module mips_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       ab_write,
  output logic       alu_out_write,
  output logic       reg_write,
  output logic       epc_write,
  output logic [1:0] alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       exc_cause,
  output logic [4:0] state
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       exc_q, exc_d;
  logic       last;
  ctrl_t      ctrl;

  assign last = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: if (last) state_d = ST_DECODE;
      ST_DECODE: begin
        if (opcode == OP_RTYPE && is_legal_r(funct)) state_d = ST_EXEC_R;
        else if (opcode == OP_ADDI)                  state_d = ST_EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW) state_d = ST_MEM_ADDR;
        else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = ST_BRANCH;
        else if (opcode == OP_J)                     state_d = ST_JUMP;
        else begin
          state_d = ST_EXC;
          exc_d   = EXC_ILLEGAL;
        end
      end
      // AND cannot overflow, so only ADD/SUB trap.
      ST_EXEC_R: begin
        if (overflow && funct != FN_AND) begin
          state_d = ST_EXC;
          exc_d   = EXC_OVF;
        end else begin
          state_d = ST_WB_R;
        end
      end
      ST_EXEC_I: begin
        if (overflow) begin
          state_d = ST_EXC;
          exc_d   = EXC_OVF;
        end else begin
          state_d = ST_WB_I;
        end
      end
      ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_LW_READ : ST_SW_WRITE;
      ST_LW_READ:  if (last) state_d = ST_LW_WB;
      ST_SW_WRITE: if (last) state_d = ST_FETCH;
      ST_WB_R, ST_WB_I, ST_LW_WB, ST_BRANCH, ST_JUMP, ST_EXC: state_d = ST_FETCH;
      default:     state_d = ST_RST;
    endcase
  end

  // Counter restarts on every state change and stops at the final count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = 4'd0;
    else if (!last)         cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST;
      cnt_q   <= 4'd0;
      exc_q   <= EXC_OVF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end

  mips_ctrl_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .funct  (funct),
    .zero   (zero),
    .last   (last),
    .ctrl   (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign iord          = ctrl.iord;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mdr_write     = ctrl.mdr_write;
  assign ab_write      = ctrl.ab_write;
  assign alu_out_write = ctrl.alu_out_write;
  assign reg_write     = ctrl.reg_write;
  assign epc_write     = ctrl.epc_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign exc_cause     = exc_q;
  assign state         = state_q;

endmodule

// File: tb/tb_mips_control_unit.sv
// Bench for mips_control_unit: each instruction is expanded into its expected
// per-cycle output trace, which a compare process checks every cycle.
module tb_mips_control_unit;
  import mips_ctrl_pkg::*;

  localparam int LAT = 3;

  typedef struct packed {
    logic [4:0] st;
    logic       pc_write, iord, mem_write, ir_write, mdr_write;
    logic       ab_write, alu_out_write, reg_write, epc_write;
    logic [1:0] a;
    logic [2:0] b;
    logic [2:0] op;
    logic [1:0] pcs;
    logic       reg_dst, mem_to_reg, exc_cause;
  } vec_t;

  // Clock/reset and shared inputs
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  always #5 clk = ~clk;

  // Main DUT (MEM_LAT=3) outputs
  logic pc_write, iord, mem_write, ir_write, mdr_write, ab_write;
  logic alu_out_write, reg_write, epc_write, reg_dst, mem_to_reg, exc_cause;
  logic [1:0] alu_src_a, pc_source;
  logic [2:0] alu_src_b, alu_op;
  logic [4:0] state;

  // Second DUT (MEM_LAT=1), checked only right after reset
  logic f_pc_write, f_iord, f_mem_write, f_ir_write, f_mdr_write, f_ab_write;
  logic f_alu_out_write, f_reg_write, f_epc_write, f_reg_dst, f_mem_to_reg, f_exc_cause;
  logic [1:0] f_alu_src_a, f_pc_source;
  logic [2:0] f_alu_src_b, f_alu_op;
  logic [4:0] f_state;

  mips_control_unit #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .pc_write(pc_write), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .mdr_write(mdr_write), .ab_write(ab_write),
    .alu_out_write(alu_out_write), .reg_write(reg_write), .epc_write(epc_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .exc_cause(exc_cause), .state(state)
  );

  mips_control_unit #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .pc_write(f_pc_write), .iord(f_iord), .mem_write(f_mem_write),
    .ir_write(f_ir_write), .mdr_write(f_mdr_write), .ab_write(f_ab_write),
    .alu_out_write(f_alu_out_write), .reg_write(f_reg_write), .epc_write(f_epc_write),
    .alu_src_a(f_alu_src_a), .alu_src_b(f_alu_src_b), .alu_op(f_alu_op),
    .pc_source(f_pc_source), .reg_dst(f_reg_dst), .mem_to_reg(f_mem_to_reg),
    .exc_cause(f_exc_cause), .state(f_state)
  );

  // Scoreboard
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_exc    = 1'b0;

  function automatic vec_t act_vec();
    vec_t v;
    v = {state, pc_write, iord, mem_write, ir_write, mdr_write, ab_write,
         alu_out_write, reg_write, epc_write, alu_src_a, alu_src_b, alu_op,
         pc_source, reg_dst, mem_to_reg, exc_cause};
    return v;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e, a;
      e = exp_q.pop_front();
      a = act_vec();
      n_checks++;
      if (a !== e)
        begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t state: got %0d want %0d; vector: got %h want %h",
                   $time, a.st, e.st, a, e);
        end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Reference model: expand one instruction into its cycle trace
  function automatic vec_t base(input state_t s);
    vec_t v;
    v = '0;
    v.st = s;
    v.exc_cause = m_exc;
    return v;
  endfunction

  task automatic push_trap(input logic cause);
    vec_t v;
    m_exc = cause;
    v = base(ST_EXC);
    v.epc_write = 1'b1; v.pcs = 2'b11; v.pc_write = 1'b1;
    exp_q.push_back(v);
  endtask

  task automatic gen(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
    vec_t v;
    for (int i = 0; i < LAT; i++) begin
      v = base(ST_FETCH);
      v.b = 3'b001; v.op = 3'b001;
      if (i == LAT - 1) begin v.ir_write = 1'b1; v.pc_write = 1'b1; end
      exp_q.push_back(v);
    end
    v = base(ST_DECODE);
    v.ab_write = 1'b1; v.b = 3'b011; v.op = 3'b001; v.alu_out_write = 1'b1;
    exp_q.push_back(v);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      v = base(ST_EXEC_R);
      v.a = 2'b01; v.alu_out_write = 1'b1;
      v.op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
      exp_q.push_back(v);
      if (ov && fn != 6'h24) push_trap(1'b0);
      else begin
        v = base(ST_WB_R); v.reg_write = 1'b1; v.reg_dst = 1'b1;
        exp_q.push_back(v);
      end
    end else if (op == 6'h08) begin
      v = base(ST_EXEC_I);
      v.a = 2'b01; v.b = 3'b010; v.op = 3'b001; v.alu_out_write = 1'b1;
      exp_q.push_back(v);
      if (ov) push_trap(1'b0);
      else begin
        v = base(ST_WB_I); v.reg_write = 1'b1;
        exp_q.push_back(v);
      end
    end else if (op == 6'h23 || op == 6'h2B) begin
      v = base(ST_MEM_ADDR);
      v.a = 2'b01; v.b = 3'b010; v.op = 3'b001; v.alu_out_write = 1'b1;
      exp_q.push_back(v);
      for (int i = 0; i < LAT; i++) begin
        v = base(op == 6'h23 ? ST_LW_READ : ST_SW_WRITE);
        v.iord = 1'b1;
        if (op == 6'h23) v.mdr_write = (i == LAT - 1);
        else             v.mem_write = 1'b1;
        exp_q.push_back(v);
      end
      if (op == 6'h23) begin
        v = base(ST_LW_WB); v.reg_write = 1'b1; v.mem_to_reg = 1'b1;
        exp_q.push_back(v);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      v = base(ST_BRANCH);
      v.a = 2'b01; v.op = 3'b010; v.pcs = 2'b01;
      v.pc_write = (op == 6'h04) ? z : !z;
      exp_q.push_back(v);
    end else if (op == 6'h02) begin
      v = base(ST_JUMP); v.pcs = 2'b10; v.pc_write = 1'b1;
      exp_q.push_back(v);
    end else begin
      push_trap(1'b1);
    end
  endtask

  // Driver tasks
  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d entries left want 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
    opcode = op; funct = fn; zero = z; overflow = ov;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
    set_in(op, fn, z, ov);
    gen(op, fn, z, ov);
    drain();
  endtask

  logic [5:0] op_pool[10] = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h0C};
  logic [5:0] fn_pool[5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00};

  initial begin
    vec_t v;
    reset = 1'b1;
    set_in(6'h00, 6'h20, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // RST cycle: all zero on both instances
    m_exc = 1'b0;
    exp_q.push_back(base(ST_RST));
    @(negedge clk); #1;
    chk("rst_state_lat1", 32'(f_state), 32'(ST_RST));
    chk("rst_enables_lat1", {f_pc_write, f_ir_write, f_ab_write, f_reg_write, f_epc_write, f_alu_src_b}, 32'd0);
    @(posedge clk); #1;

    // R-type add; MEM_LAT=1 instance shows pc_write in its first FETCH
    set_in(6'h00, 6'h20, 1'b0, 1'b0);
    gen(6'h00, 6'h20, 1'b0, 1'b0);
    chk("model_add_len", 32'(exp_q.size()), 32'd6);
    @(negedge clk); #1;
    chk("fetch_state_lat1", 32'(f_state), 32'(ST_FETCH));
    chk("fetch_pcw_lat1", {f_pc_write, f_ir_write, f_alu_src_b}, {27'd0, 5'b11001});
    drain();

    // lw with 9-cycle trace
    set_in(6'h23, 6'h00, 1'b0, 1'b0);
    gen(6'h23, 6'h00, 1'b0, 1'b0);
    chk("model_lw_len", 32'(exp_q.size()), 32'd9);
    drain();

    // Directed branches, jump, sw, traps
    run_instr(6'h04, 6'h00, 1'b1, 1'b0);
    run_instr(6'h04, 6'h00, 1'b0, 1'b0);
    run_instr(6'h05, 6'h00, 1'b0, 1'b0);
    run_instr(6'h05, 6'h00, 1'b1, 1'b0);
    run_instr(6'h2B, 6'h11, 1'b0, 1'b1);
    run_instr(6'h02, 6'h00, 1'b0, 1'b0);
    run_instr(6'h3F, 6'h20, 1'b0, 1'b0);
    chk("model_exc_illegal", 32'(m_exc), 32'd1);
    run_instr(6'h08, 6'h00, 1'b0, 1'b1);
    chk("model_exc_ovf", 32'(m_exc), 32'd0);
    run_instr(6'h00, 6'h25, 1'b0, 1'b0);
    run_instr(6'h00, 6'h22, 1'b0, 1'b1);
    run_instr(6'h00, 6'h24, 1'b0, 1'b1);
    run_instr(6'h23, 6'h00, 1'b0, 1'b1);

    // Reset in the 2nd LW_READ cycle: trace cut short, then RST
    set_in(6'h23, 6'h00, 1'b0, 1'b0);
    gen(6'h23, 6'h00, 1'b0, 1'b0);
    while (exp_q.size() > LAT + 4) v = exp_q.pop_back();
    m_exc = 1'b0;
    exp_q.push_back(base(ST_RST));
    repeat (LAT + 3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    drain();

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      op = op_pool[$urandom_range(0, 9)];
      fn = (op == 6'h00 && $urandom_range(0, 3) != 0) ? fn_pool[$urandom_range(0, 2)]
                                                      : fn_pool[$urandom_range(0, 4)];
      run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_control_unit.md
Name: mips_control_unit

Overview:
Multicycle MIPS control FSM that sequences the shared datapath: ALU, its A/B source muxes, PC, IR, register file and memory port. It drives every mux select and write enable, including the 3-bit ALU source-B select. Instructions take 3–5+ states, and memory accesses may stretch over MEM_LAT cycles. Overflow and unknown opcode/funct trap to a fixed exception vector via EPC.

Parameters:
MEM_LAT, 1, cycles per memory read/write (range 1..15); FETCH, LW_READ and SW_WRITE each last MEM_LAT cycles.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26], stable from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, combinational, same cycle
overflow  in  1  ALU signed-overflow flag, combinational, same cycle
pc_write  out  1  PC load enable
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
mdr_write  out  1  MDR load enable
ab_write  out  1  A/B register load enable
alu_out_write  out  1  ALUOut load enable
reg_write  out  1  register-file write enable
epc_write  out  1  EPC load enable
alu_src_a  out  2  ALU A source: 00 = PC, 01 = A
alu_src_b  out  3  ALU B source: 000 = B, 001 = const 4, 010 = sign-ext imm, 011 = sign-ext imm<<2, 100 = A
alu_op  out  3  ALU function: 001 = ADD, 010 = SUB, 011 = AND
pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector
reg_dst  out  1  destination register: 0 = rt, 1 = rd
mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR
exc_cause  out  1  exception cause: 0 = overflow, 1 = illegal opcode/funct
state  out  5  current state, for debug

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high. While reset is high at a rising edge, the FSM goes to RST and the wait counter clears. All enables and selects are 0 in RST. RST lasts one cycle, then FETCH.
- Reset mid-instruction aborts the instruction with no further writes. A reset in the same cycle as a write-enable state still allows that cycle's combinational enable; the next cycle is RST.
- Outputs are Moore (state decode) with two exceptions: alu_op in EXEC_R follows funct, and pc_write in BRANCH follows zero. Any output not listed for a state is 0.
- FETCH (MEM_LAT cycles): iord=0, alu_src_a=00, alu_src_b=001, alu_op=ADD. On the final count only, ir_write=1 and pc_write=1 with pc_source=00. Then DECODE.
- DECODE: ab_write=1, alu_src_a=00, alu_src_b=011, alu_op=ADD, alu_out_write=1 (branch target). Dispatch on opcode:
  - 0x00 with funct 0x20/0x22/0x24 → EXEC_R
  - 0x08 → EXEC_I
  - 0x23/0x2B → MEM_ADDR
  - 0x04/0x05 → BRANCH
  - 0x02 → JUMP
  - anything else, including R-type with another funct → EXC, exc_cause=1
- EXEC_R: alu_src_a=01, alu_src_b=000, alu_op = ADD/SUB/AND for funct 0x20/0x22/0x24; alu_out_write=1. If overflow=1 and funct≠0x24 → EXC with exc_cause=0; else → WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- EXEC_I: alu_src_a=01, alu_src_b=010, alu_op=ADD, alu_out_write=1. If overflow → EXC with exc_cause=0; else → WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- MEM_ADDR: alu_src_a=01, alu_src_b=010, alu_op=ADD, alu_out_write=1. No overflow trap. Then LW_READ for 0x23 or SW_WRITE for 0x2B.
- LW_READ (MEM_LAT cycles): iord=1; mdr_write=1 on the final count. Then LW_WB.
- LW_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
- SW_WRITE (MEM_LAT cycles): iord=1, mem_write=1 for every cycle. Then FETCH.
- BRANCH: alu_src_a=01, alu_src_b=000, alu_op=SUB, pc_source=01. pc_write = zero for 0x04, !zero for 0x05. Then FETCH.
- JUMP: pc_source=10, pc_write=1. Then FETCH.
- EXC (1 cycle):
  - epc_write=1; EPC captures PC, i.e. the address of the next instruction.
  - pc_source=11, pc_write=1.
  - exc_cause is registered at the trap decision and holds until the next trap or reset (reset value 0). Then FETCH.
- The wait counter is 4 bits. It is cleared on entry to every multi-cycle state and never wraps; the state exits when count == MEM_LAT-1. MEM_LAT=1 gives single-cycle states.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum
  - opcode/funct constants
  - ALU_OP codes
  - ALU source A/B and PC source select encodings
  - EXC cause codes
- Sub-module mips_ctrl_decode: purely combinational map from (state, funct, zero, opcode) to all control outputs.
- The top level keeps the state register, wait counter, exc_cause register and next-state logic.

Test Plan:
- Reset sequence: reset high 2 cycles, then low → state=RST for one cycle with all outputs 0, then FETCH with alu_src_b=001. With MEM_LAT=1, pc_write=1 in that FETCH cycle.
- R-type add: opcode 0x00, funct 0x20, overflow=0 → FETCH, DECODE (alu_src_b=011), EXEC_R (alu_src_b=000, alu_op=001), WB_R (reg_write=1, reg_dst=1). Total 4 cycles.
- lw with MEM_LAT=3: opcode 0x23 → FETCH 3 cycles, DECODE, MEM_ADDR (alu_src_b=010), LW_READ 3 cycles with mdr_write only on the 3rd, LW_WB. Total 9 cycles.
- beq/bne: opcode 0x04 with zero=1 → pc_write=1, pc_source=01. Opcode 0x04 with zero=0 → pc_write=0. Opcode 0x05 with zero=0 → pc_write=1.
- Traps:
  - addi (0x08) with overflow=1 in EXEC_I → EXC next: epc_write=1, pc_source=11, exc_cause=0, no reg_write.
  - opcode 0x3F → EXC from DECODE with exc_cause=1.
- Reset asserted during LW_READ (MEM_LAT=3, 2nd cycle) → next state RST; no mdr_write or reg_write ever occurs for that lw.
